// File: rtl/dino_score_ctrl.sv
// dino_score_ctrl: game-state FSM and packed-BCD score keeper for the dino game.
// Rising edges of game_start / game_over / game_tick drive an IDLE/RUN/OVER FSM.
// In RUN, every TICKS_PER_PT tick events add one point to a DIGITS-digit BCD score.
// The score saturates at all nines, and a one-cycle milestone pulse marks each
// MILESTONE-point boundary.
// Optional feature: define HISCORE_EN to add the hi_score output and its tracking logic.
module dino_score_ctrl #(
  parameter int DIGITS       = 4,
  parameter int TICKS_PER_PT = 6,
  parameter int MILESTONE    = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  game_start,
  input  logic                  game_over,
  input  logic                  game_tick,
  output logic [4*DIGITS-1:0]   score,
  output logic                  running,
  output logic                  milestone,
  output logic                  saturated,
`ifdef HISCORE_EN
  output logic [4*DIGITS-1:0]   hi_score,
`endif
  output logic [1:0]            state_dbg
);

  localparam int SW    = 4 * DIGITS;
  localparam int DIV_W = (TICKS_PER_PT > 1) ? $clog2(TICKS_PER_PT) : 1;
  localparam int MS_W  = (MILESTONE > 1) ? $clog2(MILESTONE) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_PT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MILESTONE - 1);
  localparam logic [MS_W-1:0]  MS_ONE   = MS_W'(1);
  localparam logic [SW-1:0]    NINES    = {DIGITS{4'h9}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic [1:0]       state;
  logic             start_q, over_q, tick_q;
  logic             start_ev, over_ev, tick_ev;
  logic [DIV_W-1:0] div_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic [SW-1:0]    score_inc;
  logic             carry;
  logic [3:0]       digit;

  assign start_ev  = game_start & ~start_q;
  assign over_ev   = game_over  & ~over_q;
  assign tick_ev   = game_tick  & ~tick_q;
  assign saturated = (score == NINES);
  assign state_dbg = state;

  // Remember the previous input levels so only rising edges act.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      over_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      start_q <= game_start;
      over_q  <= game_over;
      tick_q  <= game_tick;
    end
  end

  // score + 1 in BCD: a 9 rolls to 0 and passes the carry to the next digit up.
  always_comb begin
    score_inc = score;
    carry     = 1'b1;
    digit     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = score[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = digit + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Game FSM, tick divider, score and milestone counter.
  // A game_over edge takes priority over a tick edge in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      running   <= 1'b0;
      score     <= '0;
      div_cnt   <= '0;
      ms_cnt    <= '0;
      milestone <= 1'b0;
    end else begin
      milestone <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start_ev) begin
            state   <= S_RUN;
            running <= 1'b1;
            score   <= '0;
            div_cnt <= '0;
            ms_cnt  <= '0;
          end
        end
        S_RUN: begin
          if (over_ev) begin
            state   <= S_OVER;
            running <= 1'b0;
          end else if (tick_ev) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              // At all nines the divider keeps cycling but nothing else moves.
              if (!saturated) begin
                score <= score_inc;
                if (ms_cnt == MS_LAST) begin
                  ms_cnt    <= '0;
                  milestone <= 1'b1;
                end else begin
                  ms_cnt <= ms_cnt + MS_ONE;
                end
              end
            end else begin
              div_cnt <= div_cnt + DIV_ONE;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef HISCORE_EN
  // Keep the best finished score. Packed BCD orders the same as unsigned binary,
  // so a plain compare is an MSD-first BCD compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_score <= '0;
    end else if ((state == S_RUN) && over_ev && (score > hi_score)) begin
      hi_score <= score;
    end
  end
`endif

endmodule
